// File: rtl/route_split.sv
// route_split: 1-to-2 packet switch. Bit ROUTE_BIT of each packet picks output port 0 or 1.
// Each port has a DEPTH-entry FIFO and a delivered-packet counter.
// Ports: clk, reset (sync, active-high); L_* is the input channel (valid/ready);
//        R0_*/R1_* are the per-port output channels (valid/ready); cnt0/cnt1 count
//        deliveries per port, modulo 256.
// Latency: two edges from acceptance to Rd_valid. Backpressure: a packet held for a
// full port stalls the input (head-of-line), and L_ready follows Rd_ready combinationally.
module route_split #(
  parameter int WIDTH     = 11,
  parameter int ROUTE_BIT = WIDTH - 1,
  parameter int DEPTH     = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] L_data,
  input  logic             L_valid,
  output logic             L_ready,
  output logic [WIDTH-1:0] R0_data,
  output logic             R0_valid,
  input  logic             R0_ready,
  output logic [WIDTH-1:0] R1_data,
  output logic             R1_valid,
  input  logic             R1_ready,
  output logic [7:0]       cnt0,
  output logic [7:0]       cnt1
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  // Holding register between the input channel and the port FIFOs.
  logic             hold_valid_q, hold_valid_d;
  logic [WIDTH-1:0] hold_data_q, hold_data_d;

  logic             dest;
  logic             push;
  logic             l_fire;

  // Per-port signals, index 0 = R0, index 1 = R1.
  logic [1:0]       rd_rdy;
  logic [1:0]       rd_vld;
  logic [1:0]       rd_fire;
  logic [1:0]       fifo_space;
  logic [1:0]       fifo_push;
  logic [WIDTH-1:0] rd_dat  [2];
  logic [7:0]       cnt_val [2];

  assign rd_rdy = {R1_ready, R0_ready};

  // ---------------------------------------------------------------------------
  // Input side: steering decision for the held packet.
  // ---------------------------------------------------------------------------
  assign dest = hold_data_q[ROUTE_BIT];

  // A full FIFO still has room this cycle if it is being popped; this is what
  // lets a stalled port release the held packet on the very edge it drains.
  assign push      = hold_valid_q & fifo_space[dest];
  assign fifo_push = {push & dest, push & ~dest};

  // Combinational from Rd_ready through fifo_space: keeps full rate under
  // backpressure release without a second holding stage.
  assign L_ready = ~hold_valid_q | push;
  assign l_fire  = L_valid & L_ready;

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (l_fire) begin
      hold_valid_d = 1'b1;
      hold_data_d  = L_data;
    end else if (push) begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Output side: one circular-buffer FIFO and one delivery counter per port.
  // ---------------------------------------------------------------------------
  for (genvar g = 0; g < 2; g++) begin : g_port
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [7:0]       cnt_q, cnt_d;

    assign rd_vld[g]     = (count_q != '0);
    // Head is forced to zero when empty so stale entries never show on the bus.
    assign rd_dat[g]     = rd_vld[g] ? mem_q[rd_ptr_q] : '0;
    assign rd_fire[g]    = rd_vld[g] & rd_rdy[g];
    assign fifo_space[g] = (count_q < DEPTH_C) | rd_fire[g];
    assign cnt_val[g]    = cnt_q;

    always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      cnt_d    = cnt_q;

      if (fifo_push[g]) begin
        wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      end
      if (rd_fire[g]) begin
        rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        cnt_d    = cnt_q + 8'd1;
      end

      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({fifo_push[g], rd_fire[g]})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        count_q  <= '0;
        cnt_q    <= '0;
      end else begin
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        count_q  <= count_d;
        cnt_q    <= cnt_d;
      end
    end

    // Storage needs no reset: it is only visible through rd_dat, which is
    // masked whenever the occupancy is zero.
    always_ff @(posedge clk) begin
      if (fifo_push[g]) begin
        mem_q[wr_ptr_q] <= hold_data_q;
      end
    end
  end

  assign R0_valid = rd_vld[0];
  assign R0_data  = rd_dat[0];
  assign R1_valid = rd_vld[1];
  assign R1_data  = rd_dat[1];
  assign cnt0     = cnt_val[0];
  assign cnt1     = cnt_val[1];

endmodule

// File: tb/tb_route_split.sv
// Testbench for route_split: directed scenarios with literal expectations plus a
// randomized phase, all cross-checked every cycle against a queue-based model.
module tb_route_split;

  localparam int WIDTH = 11;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [WIDTH-1:0] L_data = '0;
  logic             L_valid = 1'b0;
  logic             L_ready;
  logic [WIDTH-1:0] R0_data;
  logic             R0_valid;
  logic             R0_ready = 1'b0;
  logic [WIDTH-1:0] R1_data;
  logic             R1_valid;
  logic             R1_ready = 1'b0;
  logic [7:0]       cnt0;
  logic [7:0]       cnt1;

  int checks = 0;
  int errors = 0;

  route_split #(.WIDTH(WIDTH), .ROUTE_BIT(WIDTH-1), .DEPTH(DEPTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .L_data   (L_data),
    .L_valid  (L_valid),
    .L_ready  (L_ready),
    .R0_data  (R0_data),
    .R0_valid (R0_valid),
    .R0_ready (R0_ready),
    .R1_data  (R1_data),
    .R1_valid (R1_valid),
    .R1_ready (R1_ready),
    .cnt0     (cnt0),
    .cnt1     (cnt1)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model: a holding slot and two packet queues. Inputs change only
  // just after posedge, so at negedge the model can check the outputs for this
  // cycle and then apply what the coming edge will do.
  // ---------------------------------------------------------------------------
  bit               m_on = 1'b0;
  bit               m_hv;
  logic [WIDTH-1:0] m_hd;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];
  logic [7:0]       m_c0, m_c1;

  always @(negedge clk) begin
    logic             e_v0, e_v1, e_lr, f0, f1, room, psh, lf;
    logic [WIDTH-1:0] e_d0, e_d1;
    if (reset) begin
      m_on = 1'b1;
      m_hv = 1'b0;
      m_hd = '0;
      q0.delete();
      q1.delete();
      m_c0 = 8'd0;
      m_c1 = 8'd0;
    end else if (m_on) begin
      e_v0 = (q0.size() != 0);
      e_v1 = (q1.size() != 0);
      e_d0 = e_v0 ? q0[0] : '0;
      e_d1 = e_v1 ? q1[0] : '0;
      f0   = e_v0 && R0_ready;
      f1   = e_v1 && R1_ready;
      if (m_hd[WIDTH-1]) room = (q1.size() < DEPTH) || f1;
      else               room = (q0.size() < DEPTH) || f0;
      psh  = m_hv && room;
      e_lr = !m_hv || psh;
      lf   = L_valid && e_lr;

      cmp("L_ready",  32'(L_ready),  32'(e_lr));
      cmp("R0_valid", 32'(R0_valid), 32'(e_v0));
      cmp("R0_data",  32'(R0_data),  32'(e_d0));
      cmp("R1_valid", 32'(R1_valid), 32'(e_v1));
      cmp("R1_data",  32'(R1_data),  32'(e_d1));
      cmp("cnt0",     32'(cnt0),     32'(m_c0));
      cmp("cnt1",     32'(cnt1),     32'(m_c1));

      if (f0) begin void'(q0.pop_front()); m_c0 = m_c0 + 8'd1; end
      if (f1) begin void'(q1.pop_front()); m_c1 = m_c1 + 8'd1; end
      if (psh) begin
        if (m_hd[WIDTH-1]) q1.push_back(m_hd);
        else               q0.push_back(m_hd);
      end
      if (lf) begin
        m_hv = 1'b1;
        m_hd = L_data;
      end else if (psh) begin
        m_hv = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic r0, input logic r1);
    L_valid  = v;
    L_data   = d;
    R0_ready = r0;
    R1_ready = r1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] alt [4];
    logic [3:0]       bp_exp;

    // Reset held for two edges.
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    #1;
    cmp("rst_R0_valid", 32'(R0_valid), 32'd0);
    cmp("rst_R1_valid", 32'(R1_valid), 32'd0);
    cmp("rst_R0_data",  32'(R0_data),  32'd0);
    cmp("rst_cnt0",     32'(cnt0),     32'd0);
    cmp("rst_cnt1",     32'(cnt1),     32'd0);
    cmp("rst_L_ready",  32'(L_ready),  32'd1);

    // Single packet to R1: visible two edges after acceptance.
    drive(1'b1, 11'h5A5, 1'b1, 1'b1);
    #1;
    cmp("single_L_ready", 32'(L_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    tick();
    cmp("single_R1_valid", 32'(R1_valid), 32'd1);
    cmp("single_R1_data",  32'(R1_data),  32'h5A5);
    cmp("single_R0_valid", 32'(R0_valid), 32'd0);
    tick();
    cmp("single_cnt1",     32'(cnt1),     32'd1);
    cmp("single_R1_empty", 32'(R1_valid), 32'd0);

    // Alternating destinations back-to-back: never stalls.
    alt[0] = 11'h001; alt[1] = 11'h401; alt[2] = 11'h002; alt[3] = 11'h402;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, alt[i], 1'b1, 1'b1);
      #1;
      cmp("alt_L_ready", 32'(L_ready), 32'd1);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (3) tick();
    cmp("alt_cnt0", 32'(cnt0), 32'd2);
    cmp("alt_cnt1", 32'(cnt1), 32'd3);

    // Backpressure on R0: FIFO (2) + holding register (1) absorb three packets.
    bp_exp = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 11'(11'h011 + i), 1'b0, 1'b1);
      #1;
      cmp("bp_L_ready", 32'(L_ready), 32'(bp_exp[i]));
      tick();
    end
    // One pop releases the held packet and accepts the fourth in the same edge.
    drive(1'b1, 11'h014, 1'b1, 1'b1);
    #1;
    cmp("bp_release_L_ready", 32'(L_ready), 32'd1);
    tick();
    cmp("bp_head_after_pop", 32'(R0_data), 32'h012);
    cmp("bp_cnt0",           32'(cnt0),    32'd3);

    // Head-of-line: a port-1 packet waits behind the packet stuck for R0.
    drive(1'b1, 11'h4AA, 1'b0, 1'b1);
    #1;
    cmp("hol_L_ready", 32'(L_ready), 32'd0);
    repeat (3) tick();
    cmp("hol_R1_valid", 32'(R1_valid), 32'd0);
    drive(1'b1, 11'h4AA, 1'b1, 1'b1);
    #1;
    cmp("hol_accept", 32'(L_ready), 32'd1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (5) tick();
    cmp("hol_cnt1", 32'(cnt1), 32'd4);
    cmp("hol_cnt0", 32'(cnt0), 32'd6);

    // Counter wrap: 257 deliveries on R0 from a fresh reset.
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    for (int i = 0; i < 257; i++) begin
      drive(1'b1, 11'($urandom) & 11'h3FF, 1'b1, 1'b1);
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (4) tick();
    cmp("wrap_cnt0", 32'(cnt0), 32'd1);
    cmp("wrap_cnt1", 32'(cnt1), 32'd0);

    // Reset with packets buffered: everything is discarded.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 11'($urandom), 1'b0, 1'b0);
      tick();
    end
    drive(1'b0, '0, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("mrst_R0_valid", 32'(R0_valid), 32'd0);
    cmp("mrst_R1_valid", 32'(R1_valid), 32'd0);
    cmp("mrst_cnt0",     32'(cnt0),     32'd0);
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (4) tick();
    cmp("mrst_no_emit0", 32'(cnt0), 32'd0);
    cmp("mrst_no_emit1", 32'(cnt1), 32'd0);

    // Randomized traffic with occasional resets; the model checks every cycle.
    for (int i = 0; i < 4000; i++) begin
      reset = ($urandom_range(0, 499) == 0);
      drive($urandom_range(0, 3) != 0, 11'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
      tick();
    end
    reset = 1'b0;
    drive(1'b0, '0, 1'b1, 1'b1);
    repeat (8) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
